// File: rtl/ws_array_sequencer.sv
// ws_array_sequencer
// Tile controller for the weight-stationary PE array. It loads one weight
// matrix and streams num_vec activation vectors through a per-lane skew,
// which gives a_vec the diagonal wavefront the array expects. It then drains
// the pipeline and pulses done.
// Build option: define ZERO_GATE_EN to drop pe_en for lanes whose current
// a_vec element is zero. The default build keeps every lane enabled while
// the tile runs.
module ws_array_sequencer #(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned ROW     = 8,
  parameter int unsigned COL     = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned OUT_LAT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_vec,
  input  logic [ROW*COL*SIZE-1:0] w_data,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [ROW*SIZE-1:0]     act_data,
  input  logic                    act_valid,
  output logic                    act_ready,
  output logic [ROW*SIZE-1:0]     a_vec,
  output logic [ROW*COL*SIZE-1:0] b_vec,
  output logic [ROW-1:0]          pe_en,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  // Last value of the reused counter in DRAIN; DRAIN lasts ROW-1+OUT_LAT cycles.
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ROW + OUT_LAT - 2);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] num_lat, num_lat_nxt;
  logic             accept;
  logic             run;
  logic [OUT_LAT:0] strobe_sr;

  assign cnt_inc = cnt + 1'b1;
  assign run     = (state == S_STREAM) || (state == S_DRAIN);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  // State, vector/drain counter and latched vector count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      num_lat <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      num_lat <= num_lat_nxt;
    end
  end

  // Next-state, counter update and handshake outputs.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    num_lat_nxt = num_lat;
    w_ready     = 1'b0;
    act_ready   = 1'b0;
    accept      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          num_lat_nxt = num_vec;
          cnt_nxt     = '0;
          state_nxt   = (num_vec == '0) ? S_DONE : S_WLOAD;
        end
      end
      S_WLOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        act_ready = 1'b1;
        if (act_valid) begin
          accept = 1'b1;
          if (cnt_inc == num_lat) begin
            cnt_nxt   = '0;
            state_nxt = S_DRAIN;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Weight register; it changes only on a WLOAD handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      b_vec <= '0;
    end else if ((state == S_WLOAD) && w_valid) begin
      b_vec <= w_data;
    end
  end

  // Issue strobe delay line; its top bit marks the matching array result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      strobe_sr <= '0;
    end else begin
      strobe_sr <= (strobe_sr << 1) | (OUT_LAT + 1)'(accept);
    end
  end

  assign out_valid = strobe_sr[OUT_LAT];

  for (genvar i = 0; i < ROW; i++) begin : g_lane
    localparam int unsigned STAGES = i + 1;

    logic [SIZE-1:0]        lane_in;
    logic [STAGES*SIZE-1:0] chain;

    // Bubbles and drain cycles feed zeros into the skew.
    assign lane_in = accept ? act_data[SIZE*(ROW-i)-1 -: SIZE] : '0;

    // Skew chain of i+1 stages; it shifts while the tile runs and is zero otherwise.
    always_ff @(posedge clk) begin
      if (!reset || !run) begin
        chain <= '0;
      end else begin
        chain <= (chain << SIZE) | (STAGES*SIZE)'(lane_in);
      end
    end

    assign a_vec[SIZE*(ROW-i)-1 -: SIZE] = chain[STAGES*SIZE-1 -: SIZE];

`ifdef ZERO_GATE_EN
    logic [STAGES-1:0] gate;

    // Nonzero flags ride beside the data so pe_en lines up with a_vec.
    always_ff @(posedge clk) begin
      if (!reset || !run) begin
        gate <= '0;
      end else begin
        gate <= (gate << 1) | STAGES'(lane_in != '0);
      end
    end

    assign pe_en[i] = gate[STAGES-1] & run;
`else
    assign pe_en[i] = run;
`endif
  end

endmodule

// File: tb/tb_ws_array_sequencer.sv
// Self-checking bench for ws_array_sequencer with the default parameters.
module tb_ws_array_sequencer;

  localparam int unsigned SIZE    = 8;
  localparam int unsigned ROW     = 8;
  localparam int unsigned COL     = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned OUT_LAT = 16;
  localparam int unsigned AW      = ROW * SIZE;
  localparam int unsigned WW      = ROW * COL * SIZE;
  localparam int          DRAIN_LEN = ROW - 1 + OUT_LAT;
`ifdef ZERO_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic [WW-1:0]    w_data;
  logic             w_valid;
  logic             w_ready;
  logic [AW-1:0]    act_data;
  logic             act_valid;
  logic             act_ready;
  logic [AW-1:0]    a_vec;
  logic [WW-1:0]    b_vec;
  logic [ROW-1:0]   pe_en;
  logic             out_valid;
  logic             busy;
  logic             done;

  ws_array_sequencer #(
    .SIZE   (SIZE),
    .ROW    (ROW),
    .COL    (COL),
    .CNT_W  (CNT_W),
    .OUT_LAT(OUT_LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_vec  (num_vec),
    .w_data   (w_data),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .act_data (act_data),
    .act_valid(act_valid),
    .act_ready(act_ready),
    .a_vec    (a_vec),
    .b_vec    (b_vec),
    .pe_en    (pe_en),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle values (absent key means 0) and expected event cycles.
  bit            exp_wr[int];
  bit            exp_ar[int];
  bit            exp_busy[int];
  bit            exp_run[int];
  logic [AW-1:0] exp_av[int];
  logic [WW-1:0] b_change[int];
  logic [WW-1:0] exp_b = '0;
  int            ov_q[$];
  int            done_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  logic [AW-1:0]  av_x;
  logic [ROW-1:0] pe_x;
  int             ev;

  logic [AW-1:0] beats_q[$];
  int            gaps_q[$];

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares per-cycle levels and pops event queues when the DUT pulses.
  always @(negedge clk) begin
    if (mon_on) begin
      if (b_change.exists(cyc)) exp_b = b_change[cyc];
      av_x = exp_av.exists(cyc) ? exp_av[cyc] : '0;
      for (int i = 0; i < ROW; i++)
        pe_x[i] = exp_run.exists(cyc) && (!GATE || (av_x[SIZE*(ROW-i)-1 -: SIZE] != '0));
      chk("w_ready", WW'(w_ready), WW'(exp_wr.exists(cyc)));
      chk("act_ready", WW'(act_ready), WW'(exp_ar.exists(cyc)));
      chk("busy", WW'(busy), WW'(exp_busy.exists(cyc)));
      chk("pe_en", WW'(pe_en), WW'(pe_x));
      chk("a_vec", WW'(a_vec), WW'(av_x));
      chk("b_vec", b_vec, exp_b);

      if (ov_q.size() > 0 && ov_q[0] < cyc) begin
        checks++; errors++;
        ev = ov_q.pop_front();
        $display("FAIL out_valid_missing cyc=%0d got=none exp=cycle %0d", cyc, ev);
      end
      if (out_valid !== 1'b0) begin
        checks++;
        if (ov_q.size() == 0) begin
          errors++;
          $display("FAIL out_valid_extra cyc=%0d got=%b exp=0", cyc, out_valid);
        end else begin
          ev = ov_q.pop_front();
          if (ev != cyc) begin
            errors++;
            $display("FAIL out_valid_cycle got=cycle %0d exp=cycle %0d", cyc, ev);
          end
        end
      end

      if (done_q.size() > 0 && done_q[0] < cyc) begin
        checks++; errors++;
        ev = done_q.pop_front();
        $display("FAIL done_missing cyc=%0d got=none exp=cycle %0d", cyc, ev);
      end
      if (done !== 1'b0) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_extra cyc=%0d got=%b exp=0", cyc, done);
        end else begin
          ev = done_q.pop_front();
          if (ev != cyc) begin
            errors++;
            $display("FAIL done_cycle got=cycle %0d exp=cycle %0d", cyc, ev);
          end
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next();
  endtask

  function automatic logic [AW-1:0] mk_beat(input int base, input int zmask);
    logic [AW-1:0] b;
    int m;
    b = '0;
    m = zmask;
    for (int i = 0; i < ROW; i++)
      b[SIZE*(ROW-i)-1 -: SIZE] = m[i] ? '0 : SIZE'(base + i);
    return b;
  endfunction

  function automatic logic [WW-1:0] mk_w(input int base, input int step);
    logic [WW-1:0] w;
    for (int k = 0; k < ROW*COL; k++)
      w[(ROW*COL-k)*SIZE-1 -: SIZE] = SIZE'(base + step * k);
    return w;
  endfunction

  // Drives one tile from the current cycle and records what it must produce.
  // rst_beat >= 0 pulls reset low for two cycles where that beat would go.
  // poke pulses start once in DRAIN and once in DONE.
  task automatic do_tile(input int n, input logic [WW-1:0] w, input int rst_beat, input bit poke);
    int s, c, last, abort, k, x;
    int g[$];
    logic [AW-1:0] tmp;
    g = gaps_q;
    start   = 1'b1;
    num_vec = CNT_W'(n);
    s = cyc + 1;
    abort = 32'h3fff_ffff;
    if (rst_beat >= 0) begin
      abort = s + 1 + rst_beat;
      for (int j = 0; j <= rst_beat; j++) abort += g[j];
      abort += 1;
    end
    next();
    start   = 1'b0;
    num_vec = CNT_W'($urandom_range(1, 200));
    exp_busy[s] = 1'b1;
    if (n == 0) begin
      done_q.push_back(s);
      next();
      return;
    end
    exp_wr[s] = 1'b1;
    w_valid = 1'b1;
    w_data  = w;
    b_change[s+1] = w;
    next();
    w_valid = 1'b0;
    w_data  = ~w;
    k = 0;
    while (k < n) begin
      c = cyc;
      exp_ar[c] = 1'b1;
      exp_busy[c] = 1'b1;
      exp_run[c] = 1'b1;
      if (g[k] > 0) begin
        g[k] = g[k] - 1;
        act_valid = 1'b0;
        act_data  = AW'({$urandom, $urandom});
        next();
      end else if (k == rst_beat) begin
        act_valid = 1'b0;
        reset = 1'b0;
        b_change[abort] = '0;
        next();
        next();
        reset = 1'b1;
        return;
      end else begin
        act_valid = 1'b1;
        act_data  = beats_q[k];
        for (int i = 0; i < ROW; i++) begin
          x = c + 1 + i;
          if (x < abort) begin
            tmp = exp_av.exists(x) ? exp_av[x] : '0;
            tmp[SIZE*(ROW-i)-1 -: SIZE] = beats_q[k][SIZE*(ROW-i)-1 -: SIZE];
            exp_av[x] = tmp;
          end
        end
        if (c + 1 + OUT_LAT < abort) ov_q.push_back(c + 1 + OUT_LAT);
        k++;
        next();
      end
    end
    last = cyc - 1;
    for (int j = last + 1; j <= last + DRAIN_LEN; j++) begin
      exp_busy[j] = 1'b1;
      exp_run[j] = 1'b1;
    end
    exp_busy[last+DRAIN_LEN+1] = 1'b1;
    done_q.push_back(last + DRAIN_LEN + 1);
    // act_valid stays up into DRAIN; act_ready is low, so nothing is taken.
    act_valid = 1'b1;
    act_data  = AW'({$urandom, $urandom});
    next();
    act_valid = 1'b0;
    if (poke) begin
      start   = 1'b1;
      num_vec = CNT_W'(2);
      next();
      start = 1'b0;
    end
    while (cyc < last + DRAIN_LEN + 1) next();
    if (poke) start = 1'b1;
    next();
    start = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    num_vec   = '0;
    w_data    = '0;
    w_valid   = 1'b0;
    act_data  = '0;
    act_valid = 1'b0;
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    next();
    reset = 1'b1;
    idle(3);

    // Single vector, lane i = i+1, unit weights: pure skew timing.
    beats_q = '{mk_beat(1, 0)};
    gaps_q  = '{0};
    do_tile(1, mk_w(1, 0), -1, 1'b0);
    idle(4);

    // Four vectors with a two-cycle bubble before the third.
    beats_q = '{mk_beat(8'h11, 0), mk_beat(8'h21, 0), mk_beat(8'h31, 0), mk_beat(8'h41, 0)};
    gaps_q  = '{0, 0, 2, 0};
    do_tile(4, mk_w(3, 5), -1, 1'b0);
    idle(3);

    // Same four vectors without bubbles, back to back with the next tile.
    gaps_q = '{0, 0, 0, 0};
    do_tile(4, mk_w(7, 3), -1, 1'b0);

    // Zero-length tile.
    do_tile(0, '0, -1, 1'b0);
    idle(2);

    // start pulses in DRAIN and in DONE must be ignored.
    beats_q = '{mk_beat(8'h51, 0), mk_beat(8'h61, 0), mk_beat(8'h71, 0)};
    gaps_q  = '{0, 0, 0};
    do_tile(3, mk_w(9, 1), -1, 1'b1);
    idle(3);

    // Zero elements on lanes 1, 3 and 5.
    beats_q = '{mk_beat(8'h81, 32'h2a), mk_beat(8'h91, 32'h2a), mk_beat(8'ha1, 32'h2a)};
    gaps_q  = '{0, 0, 0};
    do_tile(3, mk_w(2, 7), -1, 1'b0);
    idle(3);

    // Reset mid-STREAM: tile aborts, no done, pending results discarded.
    beats_q = '{mk_beat(8'h12, 0), mk_beat(8'h22, 0), mk_beat(8'h32, 0),
                mk_beat(8'h42, 0), mk_beat(8'h52, 0), mk_beat(8'h62, 0)};
    gaps_q  = '{0, 1, 0, 0, 0, 0};
    do_tile(6, mk_w(4, 9), 3, 1'b0);
    idle(40);

    // Normal tile after the abort.
    beats_q = '{mk_beat(8'h13, 0), mk_beat(8'h23, 0)};
    gaps_q  = '{0, 1};
    do_tile(2, mk_w(6, 2), -1, 1'b0);
    idle(30);

    mon_on = 1'b0;
    checks++;
    if (ov_q.size() != 0) begin
      errors++;
      $display("FAIL out_valid_pending got=%0d exp=0", ov_q.size());
    end
    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL done_pending got=%0d exp=0", done_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
